// File: rtl/dmem_mmio_pkg.sv
// Shared constants and MMIO register decode for the data-side memory responder.
package dmem_mmio_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1000_0000;

  localparam logic [11:0] MMIO_TXDATA      = 12'h000;
  localparam logic [11:0] MMIO_TXSTAT      = 12'h004;
  localparam logic [11:0] MMIO_MTIME_LO    = 12'h008;
  localparam logic [11:0] MMIO_MTIME_HI    = 12'h00C;
  localparam logic [11:0] MMIO_MTIMECMP_LO = 12'h010;
  localparam logic [11:0] MMIO_MTIMECMP_HI = 12'h014;

  localparam int unsigned TXSTAT_FULL  = 0;
  localparam int unsigned TXSTAT_EMPTY = 1;
  localparam int unsigned TXSTAT_OVF   = 2;

  typedef enum logic [2:0] {
    REG_TXDATA,
    REG_TXSTAT,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_NONE
  } mmio_reg_e;

  function automatic mmio_reg_e mmio_decode(input logic [11:0] offset);
    case (offset)
      MMIO_TXDATA:      return REG_TXDATA;
      MMIO_TXSTAT:      return REG_TXSTAT;
      MMIO_MTIME_LO:    return REG_MTIME_LO;
      MMIO_MTIME_HI:    return REG_MTIME_HI;
      MMIO_MTIMECMP_LO: return REG_MTIMECMP_LO;
      MMIO_MTIMECMP_HI: return REG_MTIMECMP_HI;
      default:          return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset, so the head is forced to zero while empty.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory responder: word RAM plus MMIO window with console FIFO and machine timer.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            timer_irq
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [XLEN-1:0]   ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_hit;
  mmio_reg_e         reg_sel;
  logic              ram_we;
  logic              reg_we;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp;
  logic [63:0]       mtime_nxt;
  logic [63:0]       mtimecmp_nxt;
  logic [31:0]       mmio_rdata;
  logic              unused_load;

  // Loads are side-effect free, so the load strobe plays no part here.
  assign unused_load = mem_load;

  assign mmio_hit  = (address[31:12] == MMIO_BASE[31:12]);
  assign reg_sel   = mmio_hit ? mmio_decode(address[11:0]) : REG_NONE;
  assign ram_idx   = address[RAM_AW+1:2];
  assign ram_we    = mem_store && !mmio_hit;
  assign reg_we    = mem_store && mmio_hit;
  assign fifo_push = reg_we && (reg_sel == REG_TXDATA);

  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= store_data;
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (store_data[7:0]),
    .pop   (tx_ready),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = !fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (reg_we && (reg_sel == REG_TXSTAT)) begin
      ovf <= 1'b0;
    end else if (fifo_push && fifo_full) begin
      ovf <= 1'b1;
    end
  end

  // A half-write replaces that half and suppresses the tick for the whole counter.
  always_comb begin
    mtime_nxt    = mtime + 64'd1;
    mtimecmp_nxt = mtimecmp;
    if (reg_we) begin
      case (reg_sel)
        REG_MTIME_LO:    mtime_nxt    = {mtime[63:32], store_data[31:0]};
        REG_MTIME_HI:    mtime_nxt    = {store_data[31:0], mtime[31:0]};
        REG_MTIMECMP_LO: mtimecmp_nxt = {mtimecmp[63:32], store_data[31:0]};
        REG_MTIMECMP_HI: mtimecmp_nxt = {store_data[31:0], mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      REG_TXSTAT: begin
        mmio_rdata[TXSTAT_FULL]  = fifo_full;
        mmio_rdata[TXSTAT_EMPTY] = fifo_empty;
        mmio_rdata[TXSTAT_OVF]   = ovf;
      end
      REG_MTIME_LO:    mmio_rdata = mtime[31:0];
      REG_MTIME_HI:    mmio_rdata = mtime[63:32];
      REG_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      REG_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
      default: ;
    endcase
  end

  assign load_data = mmio_hit ? XLEN'(mmio_rdata) : ram[ram_idx];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio.
module tb_dmem_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h00;
  localparam logic [31:0] A_TXSTAT = BASE + 32'h04;
  localparam logic [31:0] A_MT_LO  = BASE + 32'h08;
  localparam logic [31:0] A_MT_HI  = BASE + 32'h0C;
  localparam logic [31:0] A_CMP_LO = BASE + 32'h10;
  localparam logic [31:0] A_CMP_HI = BASE + 32'h14;

  logic        clock;
  logic        reset;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  dmem_mmio #(
    .XLEN       (32),
    .RAM_WORDS  (1024),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, load_data, exp);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic ld = 1'b0);
    address    = a;
    store_data = d;
    mem_load   = ld;
    mem_store  = 1'b1;
    @(posedge clock);
    #1;
    mem_store  = 1'b0;
    mem_load   = 1'b0;
    store_data = '0;
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b0; mem_store = 1'b0;
    address = '0; store_data = '0; tx_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", timer_irq, 1'b0);
    chk_load("rst_mtime_lo", A_MT_LO, 32'h0);
    chk_load("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
    chk_load("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
    chk_load("rst_txstat", A_TXSTAT, 32'h2);
    @(posedge clock); #1;
    reset = 1'b0;

    // RAM write/read and aliasing
    do_store(32'h40, 32'hDEAD_BEEF);
    chk_load("ram_rd", 32'h40, 32'hDEAD_BEEF);
    chk_load("ram_alias", 32'h40 + 32'd4096, 32'hDEAD_BEEF);
    chk_load("ram_byteoff", 32'h42, 32'hDEAD_BEEF);
    do_store(32'h44, 32'h1234_5678, 1'b1);
    chk_load("ram_ld_st", 32'h44, 32'h1234_5678);
    chk_load("ram_neighbor", 32'h40, 32'hDEAD_BEEF);

    // FIFO fill and overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_store(A_TXDATA, 32'h41 + i);
    chk("fill_valid", tx_valid, 1'b1);
    chk("fill_head", tx_data, 8'h41);
    chk_load("fill_txstat", A_TXSTAT, 32'h5);
    chk_load("txdata_rd0", A_TXDATA, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 8'h41 + i);
      @(posedge clock); #1;
    end
    chk("drain_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;
    chk_load("ovf_sticky", A_TXSTAT, 32'h6);
    do_store(A_TXSTAT, 32'h0);
    chk_load("ovf_clear", A_TXSTAT, 32'h2);

    // Simultaneous push/pop
    do_store(A_TXDATA, 32'h11);
    chk("pp_valid0", tx_valid, 1'b1);
    chk("pp_head0", tx_data, 8'h11);
    tx_ready = 1'b1;
    do_store(A_TXDATA, 32'h7A);
    chk("pp_valid1", tx_valid, 1'b1);
    chk("pp_head1", tx_data, 8'h7A);
    chk_load("pp_txstat", A_TXSTAT, 32'h0);
    @(posedge clock); #1;
    chk("pp_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Timer compare
    do_store(A_CMP_HI, 32'h0);
    do_store(A_CMP_LO, 32'd20);
    do_store(A_MT_LO, 32'h0);
    chk_load("mt_wr_hold", A_MT_LO, 32'h0);
    chk_load("cmp_lo_rd", A_CMP_LO, 32'd20);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clock); #1;
      chk($sformatf("irq_k%0d", k), timer_irq, (k >= 21) ? 1'b1 : 1'b0);
      if (k == 20) chk_load("mt_at20", A_MT_LO, 32'd20);
    end

    // Wrap and write priority
    do_store(A_MT_HI, 32'hFFFF_FFFF);
    do_store(A_MT_LO, 32'hFFFF_FFFE);
    chk_load("wrap_lo0", A_MT_LO, 32'hFFFF_FFFE);
    chk_load("wrap_hi0", A_MT_HI, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    chk_load("wrap_lo1", A_MT_LO, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    chk("wrap_irq_hi", timer_irq, 1'b1);
    chk_load("wrap_lo2", A_MT_LO, 32'h0);
    chk_load("wrap_hi2", A_MT_HI, 32'h0);
    @(posedge clock); #1;
    chk("wrap_irq_lo", timer_irq, 1'b0);
    do_store(A_MT_LO, 32'd5);
    chk_load("prio_lo5", A_MT_LO, 32'd5);
    chk_load("prio_hi0", A_MT_HI, 32'h0);
    @(posedge clock); #1;
    chk_load("prio_lo6", A_MT_LO, 32'd6);

    // Unmapped offsets
    do_store(BASE + 32'h20, 32'h0000_ABCD);
    chk_load("unmapped_20", BASE + 32'h20, 32'h0);
    chk_load("unmapped_18", BASE + 32'h18, 32'h0);

    // Async reset mid-drain
    for (int i = 0; i < 3; i++) do_store(A_TXDATA, 32'h31 + i);
    chk("ar_valid_pre", tx_valid, 1'b1);
    address = A_MT_LO;
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", tx_valid, 1'b0);
    chk("ar_data", tx_data, 8'h00);
    chk("ar_mt_lo", load_data, 32'h0);
    chk_load("ar_mt_hi", A_MT_HI, 32'h0);
    chk_load("ar_ram", 32'h40, 32'hDEAD_BEEF);
    chk_load("ar_txstat", A_TXSTAT, 32'h2);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_ar_valid", tx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the pipelined RV32 core: it serves the core's MEM-stage load/store port with a word-addressed RAM and a small MMIO region. The region holds a console byte FIFO, drained through a valid/ready port, and a 64-bit machine timer with a compare interrupt. The block sits outside the core at top level and connects directly to the core's memory port: `mem_load`, `mem_store`, `address`, `store_data` and `load_data`.

## Interface
- `XLEN`, 32, data/address width
- `RAM_WORDS`, 1024, RAM depth in 32-bit words (power of two)
- `MMIO_BASE`, 32'h1000_0000, base of 4 KiB MMIO window (4 KiB aligned)
- `FIFO_DEPTH`, 4, console FIFO entries (power of two)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `mem_load`  in  1  core load strobe (MEM stage)
- `mem_store`  in  1  core store strobe (MEM stage)
- `address`  in  XLEN  byte address from core
- `store_data`  in  XLEN  full word to write, already byte-merged by the core
- `load_data`  out  XLEN  word at `address`, combinational
- `tx_data`  out  8  FIFO head byte
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  consumer accepts `tx_data` this cycle
- `timer_irq`  out  1  registered `mtime >= mtimecmp`

## Operation
- **Address decode**
  - MMIO hit: `address[31:12] == MMIO_BASE[31:12]`.
  - Otherwise RAM: index = `address[log2(RAM_WORDS)+1:2]`. Higher bits alias, and `address[1:0]` is ignored.
- **Reads**
  - `load_data` is always driven from `address`, independent of `mem_load`. The core's store path reads `load_data` to merge sub-word stores.
  - Reads have no side effects.
- **Writes**
  - A write occurs at the rising edge where `mem_store`=1.
  - If `mem_load` and `mem_store` are both 1, the access is treated as a store.
  - RAM is not reset; its contents are undefined until written.
- **MMIO map (byte offsets)**
  - 0x00 TXDATA
    - Write pushes `store_data[7:0]`.
    - Read returns 0.
  - 0x04 TXSTAT
    - Read returns {29'b0, ovf, empty, full}.
    - Any write clears `ovf`.
  - 0x08 MTIME_LO / 0x0C MTIME_HI: read/write halves of `mtime`.
  - 0x10 MTIMECMP_LO / 0x14 MTIMECMP_HI: read/write halves of `mtimecmp`.
  - Other offsets: read 0, writes ignored.
- **FIFO**
  - `tx_valid` = !empty; `tx_data` = head entry.
  - A pop happens when `tx_valid && tx_ready`.
  - A push when full is dropped and sets sticky `ovf`, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: both happen and the count is unchanged.
  - A push into an empty FIFO is not visible on `tx_valid` until the next cycle.
- **Timer**
  - `mtime` increments by 1 every cycle and wraps at 2^64 to 0.
  - A write to MTIME_LO or MTIME_HI replaces that half with `store_data`. The other half is held and there is no increment that cycle.
  - `timer_irq` is registered from the compare of the updated values. It updates one cycle after `mtime` or `mtimecmp` change.

## Timing
- **Reset values**
  - FIFO empty, `ovf`=0.
  - `tx_valid`=0, `tx_data`=0.
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `timer_irq`=0.
- **Load latency**: 0 cycles, combinational from `address` to `load_data`.
- **Read-after-write**: a store at edge N is visible on `load_data` in the cycle after edge N. This matches the core's one-store-per-cycle MEM stage, so no stall signal exists.
- **Handshake**: `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- **Reset mid-operation**
  - Asserting `reset` immediately empties the FIFO and zeroes `mtime`; `tx_valid` drops asynchronously.
  - RAM content is unaffected.
- **Cross-half carry**: there is no atomic 64-bit read. Software reads HI/LO/HI to handle the carry.

## Structure
- A shared package holds:
  - MMIO offset constants: `MMIO_TXDATA`, `MMIO_TXSTAT`, `MMIO_MTIME_LO/HI`, `MMIO_MTIMECMP_LO/HI`.
  - Default `MMIO_BASE`.
  - The TXSTAT bit positions.
- One sub-module, `tx_fifo`, contains:
  - Parameterized depth and width 8.
  - Pointers one bit wider than the index, for full/empty.
  - Ports: push, din, pop, dout, full, empty.
- RAM, decode and timer stay in the top module.

## Test plan
- **RAM write/read**: store 0xDEADBEEF at 0x40, then load 0x40 → `load_data`=0xDEADBEEF the next cycle. Also load 0x40+4·`RAM_WORDS` → same value (alias check).
- **FIFO fill and overflow**: with `tx_ready`=0, push 0x41..0x45 → TXSTAT reads 0b101 (ovf, full). Then raise `tx_ready` → drained order is 0x41,0x42,0x43,0x44 and `tx_valid` falls after 4 cycles. Write TXSTAT → reads 0b010.
- **Simultaneous push/pop**: one entry queued, `tx_ready`=1, push 0x7A the same cycle → count stays 1, next head is 0x7A.
- **Timer compare**: write MTIMECMP_HI=0 and MTIMECMP_LO=20, then MTIME_LO=0 → `timer_irq` rises exactly when `mtime`=20 is registered plus 1 cycle.
- **Wrap and write priority**: write MTIME_HI=0xFFFFFFFF and MTIME_LO=0xFFFFFFFE → after 2 cycles `mtime` reads 0. A write to MTIME_LO=5 holds the value 5 for that edge (no increment).
- **Async reset mid-drain**: FIFO holds 3 entries with `tx_valid`=1; pulse `reset` between edges → `tx_valid`=0 immediately and `mtime`=0, while RAM word 0x40 still reads back 0xDEADBEEF.
